program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/program_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM state encoding and
// the default frame header byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream
// (sync, count lo, count hi, count x 4 data bytes, xor checksum),
// writes each assembled little-endian word into instruction memory through the
// debug port, and holds the CPU until a frame completes with a good checksum.
//
// Handshake: a byte transfers on a rising clk edge only when in_valid and
// in_ready are both 1; in_ready drops only during the single WRITE cycle, and
// in_valid=0 simply stalls the loader with every register held.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        debug_en,
  output logic [31:0] debug_addr,
  output logic [31:0] debug_data_in,
  output logic        debug_write_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [16:0] MAX_COUNT = 17'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;

  logic        accept;
  logic [15:0] count_full;

  // A byte is consumed only when offered and the loader is not writing.
  assign accept = in_valid && (state_q != ST_WRITE);

  // State register plus the frame datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // Next-state logic: frame parsing, word assembly and running checksum.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    count_full   = {in_data, count_q[7:0]};

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // Non-sync bytes are silently dropped while waiting for a frame.
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d      = ST_LEN0;
          count_d      = '0;
          word_idx_d   = '0;
          byte_idx_d   = '0;
          word_d       = '0;
          csum_d       = '0;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          count_d[7:0] = in_data;
          csum_d       = csum_q ^ in_data;
          state_d      = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          count_d = count_full;
          csum_d  = csum_q ^ in_data;
          // Oversized frames are rejected before any word reaches memory.
          if ({1'b0, count_full} > MAX_COUNT) begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end else if (count_full == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = in_data;
            2'd1:    word_d[15:8]  = in_data;
            2'd2:    word_d[23:16] = in_data;
            default: word_d[31:24] = in_data;
          endcase
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = ((word_idx_q + 16'd1) == count_q) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; a low reset forces reset values immediately so a pending
  // write strobe never escapes in the reset cycle.
  always_comb begin
    in_ready       = 1'b1;
    debug_en       = 1'b0;
    debug_write_en = 1'b0;
    debug_addr     = '0;
    debug_data_in  = '0;
    cpu_hold       = 1'b1;
    load_done      = 1'b0;
    load_error     = 1'b0;
    if (reset) begin
      cpu_hold   = cpu_hold_q;
      load_done  = load_done_q;
      load_error = load_error_q;
      in_ready   = (state_q != ST_WRITE);
      case (state_q)
        ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CSUM: debug_en = 1'b1;
        // Enable rises in the very cycle the header byte is accepted.
        default: debug_en = in_valid && (in_data == SYNC_BYTE);
      endcase
      if (state_q == ST_WRITE) begin
        debug_write_en = 1'b1;
        debug_addr     = {16'd0, word_idx_q};
        debug_data_in  = word_q;
      end
    end
  end

endmodule
